sign_track_nch: RTL and testbench

- Multi-channel sign estimator for unary/stochastic bitstreams.
- Each channel integrates its input bit into a saturating up/down counter centred on the midpoint.
- Each channel reports a registered sign with configurable hysteresis, a one-cycle sign-change pulse and saturation flags.
- Sits after bipolar unary compute kernels (adders, multipliers) to feed sign-dependent logic (ReLU, abs, comparators).

---
 rtl/sign_track_nch_pkg.sv | 27 ++
 rtl/sign_track_nch_ch.sv | 89 ++++++++
 rtl/sign_track_nch.sv | 43 ++++
 tb/tb_sign_track_nch.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sign_track_nch_pkg.sv
// Shared definitions for the multi-channel sign tracker.
// Counters are carried at a fixed internal width (CNT_W) so the per-channel
// state struct can live in a non-parameterised package. Every channel works
// in that width end to end, so MID+HYST can never overflow for any legal DEP.
package sign_pkg;

   localparam int CNT_W = 16;

   typedef logic [CNT_W-1:0] cnt_t;

   typedef struct packed {
      cnt_t cnt;
      logic sign;
      logic chg;
   } ch_state_t;

   // Counter midpoint for a DEP-bit counter.
   function automatic int mid(input int dep);
      return 1 << (dep - 1);
   endfunction

   // Counter full-scale value for a DEP-bit counter.
   function automatic int max(input int dep);
      return (1 << dep) - 1;
   endfunction

endpackage

// File: rtl/sign_track_nch_ch.sv
// Single-channel sign estimator: saturating up/down counter centred on MID,
// registered sign with a hysteresis band of +/-HYST around MID, and a
// one-cycle pulse on the cycle the registered sign takes a new value.
//
// state | meaning
// ------+---------------------------------------------------------------
// cnt   | integrated stream balance, MID = balanced, 0..MAX, no wrap
// sign  | 1 = stream judged negative, 0 = non-negative
// chg   | 1 for exactly the cycle sign shows a freshly toggled value
module sign_track_ch
   import sign_pkg::*;
#(
   parameter int DEP  = 3,
   parameter int HYST = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   input  logic value,
   output logic sign,
   output logic sign_chg,
   output logic sat_hi,
   output logic sat_lo
);

   // Reject configurations the counter width cannot represent.
   if (DEP < 2 || DEP > CNT_W - 1) begin : g_bad_dep
      $error("sign_track_ch: DEP out of range");
   end
   if (HYST < 0 || HYST >= mid(DEP)) begin : g_bad_hyst
      $error("sign_track_ch: HYST must lie in 0..MID-1");
   end

   localparam cnt_t MID_C = cnt_t'(mid(DEP));
   localparam cnt_t MAX_C = cnt_t'(max(DEP));
   // Falling below LO_TH declares negative; reaching HI_TH declares
   // non-negative. With HYST=0 both collapse onto MID.
   localparam cnt_t LO_TH = cnt_t'(mid(DEP) - HYST);
   localparam cnt_t HI_TH = cnt_t'(mid(DEP) + HYST);

   ch_state_t r_st;
   cnt_t      w_cnt_nx;
   logic      w_sign_nx;

   // Next counter value: step toward the input, holding at either rail.
   always_comb begin
      w_cnt_nx = r_st.cnt;
      if (en) begin
         if (value && (r_st.cnt != MAX_C)) begin
            w_cnt_nx = r_st.cnt + cnt_t'(1);
         end else if (!value && (r_st.cnt != '0)) begin
            w_cnt_nx = r_st.cnt - cnt_t'(1);
         end
      end
   end

   // Next sign, judged on the post-update count so sign has one cycle latency.
   always_comb begin
      w_sign_nx = r_st.sign;
      if (!r_st.sign && (w_cnt_nx < LO_TH)) begin
         w_sign_nx = 1'b1;
      end else if (r_st.sign && (w_cnt_nx >= HI_TH)) begin
         w_sign_nx = 1'b0;
      end
   end

   // State register; rst and clr both return the channel to the midpoint.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_st.cnt  <= MID_C;
         r_st.sign <= 1'b0;
         r_st.chg  <= 1'b0;
      end else begin
         r_st.cnt  <= w_cnt_nx;
         r_st.sign <= w_sign_nx;
         r_st.chg  <= w_sign_nx ^ r_st.sign;
      end
   end

   // Saturation flags decode the live counter without extra latency.
   always_comb begin
      sign     = r_st.sign;
      sign_chg = r_st.chg;
      sat_hi   = (r_st.cnt == MAX_C);
      sat_lo   = (r_st.cnt == '0);
   end

endmodule

// File: rtl/sign_track_nch.sv
// Multi-channel sign tracker for unary/stochastic bitstreams. Each channel
// is an independent sign_track_ch; only clk, rst and clr are shared.
module sign_track_nch
   import sign_pkg::*;
#(
   parameter int CH   = 4,
   parameter int DEP  = 3,
   parameter int HYST = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic [CH-1:0] en,
   input  logic [CH-1:0] value,
   output logic [CH-1:0] sign,
   output logic [CH-1:0] sign_chg,
   output logic [CH-1:0] sat_hi,
   output logic [CH-1:0] sat_lo
);

   if (CH < 1) begin : g_bad_ch
      $error("sign_track_nch: CH must be at least 1");
   end

   // One tracker per channel, no cross-channel interaction.
   for (genvar g = 0; g < CH; g++) begin : g_ch
      sign_track_ch #(
         .DEP  (DEP),
         .HYST (HYST)
      ) u_ch (
         .clk      (clk),
         .rst      (rst),
         .clr      (clr),
         .en       (en[g]),
         .value    (value[g]),
         .sign     (sign[g]),
         .sign_chg (sign_chg[g]),
         .sat_hi   (sat_hi[g]),
         .sat_lo   (sat_lo[g])
      );
   end

endmodule

// File: tb/tb_sign_track_nch.sv
// Directed bench for sign_track_nch: two instances with CH=2, DEP=3
// (MID=4, MAX=7), one with HYST=0 and one with HYST=1.
// Observed vectors are packed {sign[1:0], sign_chg[1:0], sat_hi[1:0], sat_lo[1:0]}.
module tb_sign_track_nch;

   logic       clk;
   logic       rst;
   logic       clr;
   logic [1:0] en0, val0, en1, val1;
   logic [1:0] sign0, chg0, shi0, slo0;
   logic [1:0] sign1, chg1, shi1, slo1;
   logic [7:0] obs0, obs1;

   int n_tests = 0;
   int n_fail  = 0;

   assign obs0 = {sign0, chg0, shi0, slo0};
   assign obs1 = {sign1, chg1, shi1, slo1};

   sign_track_nch #(.CH(2), .DEP(3), .HYST(0)) u_h0 (
      .clk(clk), .rst(rst), .clr(clr), .en(en0), .value(val0),
      .sign(sign0), .sign_chg(chg0), .sat_hi(shi0), .sat_lo(slo0)
   );

   sign_track_nch #(.CH(2), .DEP(3), .HYST(1)) u_h1 (
      .clk(clk), .rst(rst), .clr(clr), .en(en1), .value(val1),
      .sign(sign1), .sign_chg(chg1), .sat_hi(shi1), .sat_lo(slo1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clr();
      clr = 1'b1; en0 = 2'b00; en1 = 2'b00;
      tick();
      clr = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; clr = 1'b0;
      for (int i = 0; i < 2; i++) begin
         en0 = 2'($urandom); val0 = 2'($urandom);
         en1 = 2'($urandom); val1 = 2'($urandom);
         tick();
      end
      rst = 1'b0; en0 = 2'b00; en1 = 2'b00;
      n_tests++;
      if (obs0 !== 8'h00) begin
         n_fail++; $display("FAIL reset_h0 got=%h exp=%h", obs0, 8'h00);
      end
      n_tests++;
      if (obs1 !== 8'h00) begin
         n_fail++; $display("FAIL reset_h1 got=%h exp=%h", obs1, 8'h00);
      end
      // ch0 up to MAX, then clear mid-stream while still driving upward
      en0 = 2'b01; val0 = 2'b01;
      for (int i = 0; i < 3; i++) tick();
      n_tests++;
      if (obs0 !== 8'h04) begin
         n_fail++; $display("FAIL pre_clr_sat got=%h exp=%h", obs0, 8'h04);
      end
      clr = 1'b1;
      tick();
      clr = 1'b0; en0 = 2'b00;
      n_tests++;
      if (obs0 !== 8'h00) begin
         n_fail++; $display("FAIL clr_from_max got=%h exp=%h", obs0, 8'h00);
      end
   endtask

   task automatic test_toggle();
      logic [7:0] exp_v [4];
      logic [1:0] e_v   [4];
      logic [1:0] v_v   [4];
      exp_v = '{8'h50, 8'h40, 8'h10, 8'h00};
      e_v   = '{2'b01, 2'b00, 2'b01, 2'b00};
      v_v   = '{2'b00, 2'b00, 2'b01, 2'b00};
      do_clr();
      for (int i = 0; i < 4; i++) begin
         en0 = e_v[i]; val0 = v_v[i];
         tick();
         n_tests++;
         if (obs0 !== exp_v[i]) begin
            n_fail++; $display("FAIL toggle step%0d got=%h exp=%h", i, obs0, exp_v[i]);
         end
      end
      en0 = 2'b00;
   endtask

   task automatic test_saturation();
      logic [7:0] dn_exp [8];
      dn_exp = '{8'h00, 8'h00, 8'h50, 8'h40, 8'h40, 8'h41, 8'h41, 8'h41};
      do_clr();
      en0 = 2'b01; val0 = 2'b01;
      for (int i = 0; i < 8; i++) begin
         tick();
         n_tests++;
         if (obs0 !== ((i >= 2) ? 8'h04 : 8'h00)) begin
            n_fail++; $display("FAIL sat_up step%0d got=%h exp=%h", i, obs0,
                               (i >= 2) ? 8'h04 : 8'h00);
         end
      end
      val0 = 2'b00;
      tick();
      n_tests++;
      if (obs0 !== 8'h00) begin
         n_fail++; $display("FAIL sat_leave_hi got=%h exp=%h", obs0, 8'h00);
      end
      for (int i = 0; i < 8; i++) begin
         tick();
         n_tests++;
         if (obs0 !== dn_exp[i]) begin
            n_fail++; $display("FAIL sat_dn step%0d got=%h exp=%h", i, obs0, dn_exp[i]);
         end
      end
      val0 = 2'b01;
      tick();
      n_tests++;
      if (obs0 !== 8'h40) begin
         n_fail++; $display("FAIL sat_leave_lo got=%h exp=%h", obs0, 8'h40);
      end
      en0 = 2'b00;
   endtask

   task automatic test_hyst();
      logic [7:0] exp_v [6];
      logic [1:0] v_v   [6];
      v_v   = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
      exp_v = '{8'h00, 8'h50, 8'h40, 8'h40, 8'h10, 8'h00};
      do_clr();
      en1 = 2'b01;
      for (int i = 0; i < 6; i++) begin
         val1 = v_v[i];
         tick();
         n_tests++;
         if (obs1 !== exp_v[i]) begin
            n_fail++; $display("FAIL hyst step%0d got=%h exp=%h", i, obs1, exp_v[i]);
         end
      end
      // counter now at MID with sign 0; dither around it
      for (int i = 0; i < 6; i++) begin
         val1 = (i % 2 == 0) ? 2'b01 : 2'b00;
         tick();
         n_tests++;
         if (obs1 !== 8'h00) begin
            n_fail++; $display("FAIL hyst_dither step%0d got=%h exp=%h", i, obs1, 8'h00);
         end
      end
      en1 = 2'b00;
   endtask

   task automatic test_enable();
      do_clr();
      en0 = 2'b01; val0 = 2'b00;
      tick();
      en0 = 2'b00;
      for (int i = 0; i < 5; i++) begin
         val0 = (i % 2 == 0) ? 2'b11 : 2'b00;
         tick();
         n_tests++;
         if (obs0 !== 8'h40) begin
            n_fail++; $display("FAIL en_hold step%0d got=%h exp=%h", i, obs0, 8'h40);
         end
      end
      do_clr();
      n_tests++;
      if (obs0 !== 8'h00) begin
         n_fail++; $display("FAIL clr_from_neg got=%h exp=%h", obs0, 8'h00);
      end
      clr = 1'b1; en0 = 2'b01; val0 = 2'b00;
      tick();
      clr = 1'b0; en0 = 2'b00;
      n_tests++;
      if (obs0 !== 8'h00) begin
         n_fail++; $display("FAIL clr_vs_en got=%h exp=%h", obs0, 8'h00);
      end
      tick();
      n_tests++;
      if (obs0 !== 8'h00) begin
         n_fail++; $display("FAIL clr_vs_en_after got=%h exp=%h", obs0, 8'h00);
      end
   endtask

   task automatic test_independence();
      logic [7:0] exp_v [6];
      exp_v = '{8'h50, 8'h40, 8'h48, 8'h49, 8'h49, 8'h49};
      do_clr();
      en0 = 2'b11; val0 = 2'b10;
      for (int i = 0; i < 6; i++) begin
         tick();
         n_tests++;
         if (obs0 !== exp_v[i]) begin
            n_fail++; $display("FAIL indep step%0d got=%h exp=%h", i, obs0, exp_v[i]);
         end
      end
      en0 = 2'b00;
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0;
      en0 = 2'b00; val0 = 2'b00; en1 = 2'b00; val1 = 2'b00;
      test_reset();
      test_toggle();
      test_saturation();
      test_hyst();
      test_enable();
      test_independence();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
